// File: rtl/dvi_decoder.sv
// -----------------------------------------------------------------------------
// dvi_decoder
//   Receive-side TMDS decoder for a three-channel DVI/HDMI link. Each channel
//   takes an already-deserialised 10-bit word per pixel clock, hunts for the
//   10-bit word boundary by looking for runs of control tokens at one bit
//   offset, then TMDS-decodes the aligned words. Channel 0 also carries
//   hsync/vsync in its control tokens.
//
// Optional feature macro: DVI_ERRCNT_EN
//   defined   -> err_count counts cycles in which any channel drops lock
//                (saturating at 16'hFFFF, cleared only by rst)
//   undefined -> err_count is tied to 0
//
// Ports
//   pxclk      in   pixel clock (only clock)
//   rst        in   synchronous active-high reset
//   data0..2   in   raw 10-bit words, channel 0 = blue, 1 = green, 2 = red;
//                   bit 0 is first on the wire
//   blue/green/red out 8  decoded pixel data (0 outside active video)
//   hsync/vsync    out 1  C0/C1 of the latest channel 0 control token
//   visible        out 1  data enable
//   lock           out 3  per-channel lock flag, bit n = channel n
//   locked         out 1  all channels locked
//   err_count      out 16 lock-loss event counter
//
// Latency: data in -> pixel outputs is two pxclk (alignment stage + output
// stage). lock/locked show the FSM state register directly.
// -----------------------------------------------------------------------------
module dvi_decoder #(
  parameter int unsigned CTRL_RUN     = 8,
  parameter int unsigned SEARCH_WORDS = 4096,
  parameter int unsigned LOSS_WORDS   = 4096
) (
  input  logic        pxclk,
  input  logic        rst,
  input  logic [9:0]  data0,
  input  logic [9:0]  data1,
  input  logic [9:0]  data2,
  output logic [7:0]  blue,
  output logic [7:0]  green,
  output logic [7:0]  red,
  output logic        hsync,
  output logic        vsync,
  output logic        visible,
  output logic [2:0]  lock,
  output logic        locked,
  output logic [15:0] err_count
);

  localparam int RW = 8;
  localparam int WW = $clog2(SEARCH_WORDS + 1);
  localparam int GW = $clog2(LOSS_WORDS + 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;

  // {is_token, C1, C0} for an aligned word
  function automatic logic [2:0] tok_decode(input logic [9:0] q);
    logic [2:0] t;
    case (q)
      10'b1101010100: t = 3'b100;
      10'b0010101011: t = 3'b101;
      10'b0101010100: t = 3'b110;
      10'b1010101011: t = 3'b111;
      default:        t = 3'b000;
    endcase
    return t;
  endfunction

  function automatic logic is_token(input logic [9:0] q);
    logic [2:0] t;
    t = tok_decode(q);
    return t[2];
  endfunction

  // Undo the transmit-side transition minimisation and DC-balance inversion
  function automatic logic [7:0] tmds_dec(input logic [9:0] q);
    logic [7:0] qm;
    logic [7:0] d;
    qm   = q[9] ? ~q[7:0] : q[7:0];
    d[0] = qm[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (qm[i] ^ qm[i-1]) : ~(qm[i] ^ qm[i-1]);
    end
    return d;
  endfunction

  logic [2:0][9:0] raw_s;
  logic [2:0][9:0] aligned_s;
  logic [2:0]      lock_cur_s;
  logic [2:0]      lock_nxt_s;

  assign raw_s = {data2, data1, data0};

  for (genvar g = 0; g < 3; g++) begin : g_ch
    state_e          state_q, state_d;
    logic [3:0]      off_q, off_d;
    logic [RW-1:0]   run_q, run_d;
    logic [WW-1:0]   word_q, word_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [9:0]      prev_q;
    logic [19:0]     window_s;
    logic            tok_s;

    // Older word sits in the low half: bit 0 of prev arrived first
    assign window_s      = {raw_s[g], prev_q};
    assign aligned_s[g]  = window_s[off_q +: 10];
    assign tok_s         = is_token(aligned_s[g]);
    assign lock_cur_s[g] = (state_q == LOCKED);
    assign lock_nxt_s[g] = (state_d == LOCKED);

    // Alignment state register and previous-word history
    always_ff @(posedge pxclk) begin
      if (rst) begin
        state_q <= HUNT;
        off_q   <= 4'd0;
        run_q   <= '0;
        word_q  <= '0;
        gap_q   <= '0;
        prev_q  <= 10'd0;
      end else begin
        state_q <= state_d;
        off_q   <= off_d;
        run_q   <= run_d;
        word_q  <= word_d;
        gap_q   <= gap_d;
        prev_q  <= raw_s[g];
      end
    end

    // Hunt/lock next-state logic
    always_comb begin
      state_d = state_q;
      off_d   = off_q;
      run_d   = run_q;
      word_d  = word_q;
      gap_d   = gap_q;
      case (state_q)
        HUNT: begin
          run_d  = tok_s ? (run_q + RW'(1)) : RW'(0);
          word_d = word_q + WW'(1);
          // Lock is checked first so it wins over a simultaneous offset step
          if (run_d == RW'(CTRL_RUN)) begin
            state_d = LOCKED;
            run_d   = '0;
            word_d  = '0;
            gap_d   = '0;
          end else if (word_d == WW'(SEARCH_WORDS)) begin
            off_d  = (off_q == 4'd9) ? 4'd0 : (off_q + 4'd1);
            run_d  = '0;
            word_d = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          gap_d = tok_s ? GW'(0) : (gap_q + GW'(1));
          if (gap_d == GW'(LOSS_WORDS)) begin
            state_d = HUNT;
            gap_d   = '0;
            run_d   = '0;
            word_d  = '0;
          end else begin
            state_d = LOCKED;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  logic [2:0][9:0] al_q;
  logic [7:0]      blue_q, green_q, red_q;
  logic            hsync_q, vsync_q, visible_q;
  logic [2:0]      tinfo_s;
  logic            all_lock_nxt_s;

  assign tinfo_s        = tok_decode(al_q[0]);
  // Gating on the next lock state keeps the pixel outputs and 'locked' in step
  assign all_lock_nxt_s = &lock_nxt_s;

  // Aligned-word pipeline stage
  always_ff @(posedge pxclk) begin
    if (rst) begin
      al_q <= '0;
    end else begin
      al_q <= aligned_s;
    end
  end

  // Pixel/sync output register
  always_ff @(posedge pxclk) begin
    if (rst) begin
      blue_q    <= 8'd0;
      green_q   <= 8'd0;
      red_q     <= 8'd0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      visible_q <= 1'b0;
    end else if (!all_lock_nxt_s) begin
      blue_q    <= 8'd0;
      green_q   <= 8'd0;
      red_q     <= 8'd0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      visible_q <= 1'b0;
    end else if (tinfo_s[2]) begin
      blue_q    <= 8'd0;
      green_q   <= 8'd0;
      red_q     <= 8'd0;
      hsync_q   <= tinfo_s[0];
      vsync_q   <= tinfo_s[1];
      visible_q <= 1'b0;
    end else begin
      // Sync levels hold through active video
      blue_q    <= tmds_dec(al_q[0]);
      green_q   <= tmds_dec(al_q[1]);
      red_q     <= tmds_dec(al_q[2]);
      visible_q <= 1'b1;
    end
  end

  assign blue    = blue_q;
  assign green   = green_q;
  assign red     = red_q;
  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign visible = visible_q;
  assign lock    = lock_cur_s;
  assign locked  = &lock_cur_s;

`ifdef DVI_ERRCNT_EN
  logic [15:0] err_q;
  logic        lost_any_s;

  // Several channels dropping together is one event
  assign lost_any_s = |(lock_cur_s & ~lock_nxt_s);

  // Saturating lock-loss counter
  always_ff @(posedge pxclk) begin
    if (rst) begin
      err_q <= 16'd0;
    end else if (lost_any_s && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end else begin
      err_q <= err_q;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_dvi_decoder.sv
// -----------------------------------------------------------------------------
// tb_dvi_decoder
//   Randomised stimulus with a behavioural reference model. Every pixel clock
//   the stimulus side drives raw words, advances the model and pushes the
//   expected post-edge outputs into a queue; a separate monitor pops one entry
//   per clock and compares it with the DUT. A few directed checks mark the
//   end of each scenario. Optional macro: DVI_ERRCNT_EN.
// -----------------------------------------------------------------------------
module tb_dvi_decoder;

  localparam int CR = 8;
  localparam int SW = 4096;
  localparam int LW = 4096;

  logic        pxclk = 1'b0;
  logic        rst   = 1'b1;
  logic [9:0]  data0 = 10'd0, data1 = 10'd0, data2 = 10'd0;
  logic [7:0]  blue, green, red;
  logic        hsync, vsync, visible, locked;
  logic [2:0]  lock;
  logic [15:0] err_count;

  always #5 pxclk = ~pxclk;

  dvi_decoder #(.CTRL_RUN(CR), .SEARCH_WORDS(SW), .LOSS_WORDS(LW)) dut (
    .pxclk(pxclk), .rst(rst),
    .data0(data0), .data1(data1), .data2(data2),
    .blue(blue), .green(green), .red(red),
    .hsync(hsync), .vsync(vsync), .visible(visible),
    .lock(lock), .locked(locked), .err_count(err_count)
  );

  typedef struct packed {
    logic [7:0]  b, g, r;
    logic        hs, vs, vis;
    logic [2:0]  lk;
    logic        lkd;
    logic [15:0] ec;
  } obs_t;

  obs_t expq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Model state (plain integers, one slot per channel)
  int m_hunting[3], m_off[3], m_run[3], m_words[3], m_gap[3], m_prev[3], m_s1[3];
  int o_b, o_g, o_r, o_hs, o_vs, o_vis, m_ec;
  int pend[3];

  int toks[4] = '{32'h354, 32'h0AB, 32'h154, 32'h2AB};  // C1C0 = 00,01,10,11

  function automatic int tok_code(input int q);
    for (int k = 0; k < 4; k++) if (q == toks[k]) return k;
    return -1;
  endfunction

  function automatic int bit_of(input int v, input int i);
    return (v >> i) & 1;
  endfunction

  // Reference TMDS decode written as arithmetic over bit positions
  function automatic int dec8(input int q);
    int qm, d, b;
    qm = bit_of(q, 9) ? ((q & 32'hFF) ^ 32'hFF) : (q & 32'hFF);
    d  = qm & 1;
    for (int i = 1; i < 8; i++) begin
      b = bit_of(qm, i) ^ bit_of(qm, i - 1);
      if (bit_of(q, 8) == 0) b = 1 - b;
      d = d + (b << i);
    end
    return d;
  endfunction

  task automatic model_step(input bit r, input int x0, input int x1, input int x2);
    int   x[3];
    int   a[3];
    bit   lost;
    int   nlock;
    int   code;
    obs_t e;
    x[0] = x0; x[1] = x1; x[2] = x2;
    if (r) begin
      for (int c = 0; c < 3; c++) begin
        m_hunting[c] = 1; m_off[c] = 0; m_run[c] = 0; m_words[c] = 0;
        m_gap[c] = 0; m_prev[c] = 0; m_s1[c] = 0;
      end
      o_b = 0; o_g = 0; o_r = 0; o_hs = 0; o_vs = 0; o_vis = 0; m_ec = 0;
    end else begin
      lost  = 1'b0;
      nlock = 0;
      for (int c = 0; c < 3; c++) begin
        a[c] = ((x[c] * 1024 + m_prev[c]) >> m_off[c]) % 1024;
        m_prev[c] = x[c];
        if (m_hunting[c] == 1) begin
          m_run[c]   = (tok_code(a[c]) >= 0) ? m_run[c] + 1 : 0;
          m_words[c] = m_words[c] + 1;
          if (m_run[c] == CR) begin
            m_hunting[c] = 0; m_run[c] = 0; m_words[c] = 0; m_gap[c] = 0;
          end else if (m_words[c] == SW) begin
            m_off[c] = (m_off[c] + 1) % 10; m_run[c] = 0; m_words[c] = 0;
          end
        end else begin
          m_gap[c] = (tok_code(a[c]) >= 0) ? 0 : m_gap[c] + 1;
          if (m_gap[c] == LW) begin
            m_hunting[c] = 1; m_gap[c] = 0; lost = 1'b1;
          end
        end
        if (m_hunting[c] == 0) nlock++;
      end
      code = tok_code(m_s1[0]);
      if (nlock != 3) begin
        o_b = 0; o_g = 0; o_r = 0; o_hs = 0; o_vs = 0; o_vis = 0;
      end else if (code >= 0) begin
        o_b = 0; o_g = 0; o_r = 0; o_vis = 0;
        o_hs = code % 2; o_vs = code / 2;
      end else begin
        o_b = dec8(m_s1[0]); o_g = dec8(m_s1[1]); o_r = dec8(m_s1[2]); o_vis = 1;
      end
      for (int c = 0; c < 3; c++) m_s1[c] = a[c];
`ifdef DVI_ERRCNT_EN
      if (lost && m_ec < 65535) m_ec++;
`else
      if (lost) m_ec = 0;
`endif
    end
    e.b   = 8'(o_b);  e.g = 8'(o_g);  e.r = 8'(o_r);
    e.hs  = 1'(o_hs); e.vs = 1'(o_vs); e.vis = 1'(o_vis);
    e.lk  = {m_hunting[2] == 0, m_hunting[1] == 0, m_hunting[0] == 0};
    e.lkd = (e.lk == 3'b111);
    e.ec  = 16'(m_ec);
    expq.push_back(e);
  endtask

  // Drive one word per channel at the inactive edge and record the expectation
  task automatic drive(input bit r, input int x0, input int x1, input int x2);
    @(negedge pxclk);
    rst   = r;
    data0 = 10'(x0); data1 = 10'(x1); data2 = 10'(x2);
    model_step(r, x0, x1, x2);
  endtask

  // Shape the serial stream so that words q land on bit offset o
  task automatic emit(input int o, input int q0, input int q1, input int q2);
    int q[3];
    int x[3];
    q[0] = q0; q[1] = q1; q[2] = q2;
    for (int c = 0; c < 3; c++) begin
      x[c]    = ((q[c] * 1024 + pend[c]) >> (10 - o)) % 1024;
      pend[c] = q[c];
    end
    drive(1'b0, x[0], x[1], x[2]);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  // Settle to just after the edge that consumes the last driven word
  task automatic settle();
    @(posedge pxclk);
    #1;
  endtask

  // Scoreboard monitor: one comparison per clock with an outstanding entry
  initial begin
    obs_t e, act;
    forever begin
      @(posedge pxclk);
      #1;
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        act = {blue, green, red, hsync, vsync, visible, lock, locked, err_count};
        n_total++;
        if (act === e) n_pass++;
        else $display("FAIL sb @%0t: got b=%h g=%h r=%h hs=%b vs=%b vis=%b lock=%b lkd=%b ec=%h expected b=%h g=%h r=%h hs=%b vs=%b vis=%b lock=%b lkd=%b ec=%h",
                      $time, act.b, act.g, act.r, act.hs, act.vs, act.vis, act.lk, act.lkd, act.ec,
                      e.b, e.g, e.r, e.hs, e.vs, e.vis, e.lk, e.lkd, e.ec);
      end
    end
  end

  initial begin
    int g, t, w;
    for (int c = 0; c < 3; c++) pend[c] = 0;

    // Reset with random data
    for (int i = 0; i < 3; i++)
      drive(1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
    settle();
    chk("reset_lock", {29'd0, lock}, 32'd0);
    chk("reset_pix", {blue, green, red, hsync, vsync, visible, locked}, 32'd0);

    // Constant garbage after release must not lock
    g = $urandom_range(0, 1023);
    for (int i = 0; i < 20; i++) drive(1'b0, g, g, g);
    settle();
    chk("garbage_lock", {29'd0, lock}, 32'd0);

    // Token 1101010100 arriving at bit offset 3 on every channel
    for (int i = 0; i < 3 * SW + 20; i++) emit(3, 32'h354, 32'h354, 32'h354);
    settle();
    chk("align_lock", {28'd0, lock, locked}, 32'hF);
    chk("align_sync", {29'd0, hsync, vsync, visible}, 32'd0);

    // Decode: 0x100 / 0x200 / 0x100 -> 00 / FF / 00
    for (int i = 0; i < 3; i++) emit(3, 32'h100, 32'h200, 32'h100);
    settle();
    chk("decode_pix", {7'd0, visible, blue, green, red}, {7'd0, 1'b1, 24'h00FF00});

    // Sync token 1010101011 then data: syncs held
    for (int i = 0; i < 3; i++) emit(3, 32'h2AB, 32'h354, 32'h354);
    settle();
    chk("sync_tok", {29'd0, hsync, vsync, visible}, 32'h6);
    for (int i = 0; i < 3; i++) emit(3, 32'h0C5, 32'h1E7, 32'h300);
    settle();
    chk("sync_hold", {29'd0, hsync, vsync, visible}, 32'h7);

    // Random locked traffic: occasional tokens between random data words
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        t = toks[$urandom_range(0, 3)];
        emit(3, t, toks[$urandom_range(0, 3)], toks[$urandom_range(0, 3)]);
      end else begin
        emit(3, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
      end
    end

    // Loss: a long stretch with no control tokens
    for (int i = 0; i < LW + 5; i++) emit(3, 32'h100, 32'h100, 32'h100);
    settle();
    chk("loss_lock", {28'd0, lock, locked}, 32'd0);
    chk("loss_pix", {blue, green, red, hsync, vsync, visible}, 32'd0);
`ifdef DVI_ERRCNT_EN
    chk("loss_errcnt", {16'd0, err_count}, 32'd1);
`else
    chk("loss_errcnt", {16'd0, err_count}, 32'd0);
`endif

    // Offset walks 3..9 then wraps to 0; relock on tokens at true offset 0
    for (int i = 0; i < 7 * SW + 50; i++) emit(3, 32'h100, 32'h100, 32'h100);
    for (int i = 0; i < 40; i++) emit(0, 32'h354, 32'h354, 32'h354);
    settle();
    chk("wrap_lock", {28'd0, lock, locked}, 32'hF);

    // Mid-stream reset while locked
    for (int i = 0; i < 2; i++) drive(1'b1, 32'h354, 32'h354, 32'h354);
    settle();
    chk("midrst_lock", {28'd0, lock, locked}, 32'd0);
    chk("midrst_errcnt", {16'd0, err_count}, 32'd0);
    for (int i = 0; i < 5; i++) drive(1'b0, 32'h354, 32'h354, 32'h354);

    // Drain scoreboard with a bounded wait
    w = 0;
    while (expq.size() > 0 && w < 20) begin
      @(posedge pxclk);
      w++;
    end
    #2;
    if (expq.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
